exe_stage: RTL

Two-slot execute pipeline stage between instruction decode and writeback, built around the combinational `alu`. Accepts decoded operations over a valid/ready handshake and registers the operands that drive the ALU. Captures `alu_result` into an output register with full backpressure support. Also keeps a retire counter and, optionally, forwarding outputs for the decode-stage hazard logic.

---
 rtl/exe_stage.sv | 131 +++++++++++++
 1 files changed

// File: rtl/exe_stage.sv
// exe_stage: two-slot (EX, WB) execute pipeline stage wrapped around an
// external combinational ALU. Decode hands over operations on a valid/ready
// handshake. The EX registers drive the ALU, and the WB registers capture the
// ALU result. Both slots support full backpressure, and a 32-bit counter
// tracks retired results.
// Optional feature: define EXE_BYPASS_EN to generate the EX/WB forwarding
// outputs. Without it, the fwd_* ports are tied to zero.
module exe_stage #(
    parameter int CTRL_W = 12,
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    output logic              id_ready,
    input  logic [CTRL_W-1:0] id_alu_control,
    input  logic [DATA_W-1:0] id_src1,
    input  logic [DATA_W-1:0] id_src2,
    input  logic [REG_W-1:0]  id_dest,
    output logic [CTRL_W-1:0] alu_control,
    output logic [DATA_W-1:0] alu_src1,
    output logic [DATA_W-1:0] alu_src2,
    input  logic [DATA_W-1:0] alu_result,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [DATA_W-1:0] wb_result,
    output logic [REG_W-1:0]  wb_dest,
    output logic              wb_err,
    output logic [31:0]       retire_cnt,
    output logic              fwd_ex_valid,
    output logic              fwd_wb_valid,
    output logic [REG_W-1:0]  fwd_ex_dest,
    output logic [REG_W-1:0]  fwd_wb_dest,
    output logic [DATA_W-1:0] fwd_ex_data,
    output logic [DATA_W-1:0] fwd_wb_data
);

    localparam logic [CTRL_W-1:0] CTRL_ONE = {{(CTRL_W-1){1'b0}}, 1'b1};

    logic              ex_valid;
    logic [REG_W-1:0]  ex_dest;
    logic              ex_adv;
    logic              accept;
    logic              wb_fire;
    logic              ex_illegal;
    logic [DATA_W-1:0] ex_result;

    // Handshake decisions: EX may move whenever WB is empty or draining
    always_comb begin
        ex_adv   = ex_valid & (~wb_valid | wb_ready);
        id_ready = ~ex_valid | ex_adv;
        accept   = id_valid & id_ready;
        wb_fire  = wb_valid & wb_ready;
    end

    // Legality of the EX control and the result as WB should see it (zero for illegal ops or x0)
    always_comb begin
        ex_illegal = (alu_control == '0) ||
                     ((alu_control & (alu_control - CTRL_ONE)) != '0);
        ex_result  = (ex_illegal || (ex_dest == '0)) ? '0 : alu_result;
    end

    // EX slot: load on accept, hold on stall, empty when it advances without a refill
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid    <= 1'b0;
            alu_control <= '0;
            alu_src1    <= '0;
            alu_src2    <= '0;
            ex_dest     <= '0;
        end else if (accept) begin
            ex_valid    <= 1'b1;
            alu_control <= id_alu_control;
            alu_src1    <= id_src1;
            alu_src2    <= id_src2;
            ex_dest     <= id_dest;
        end else if (ex_adv) begin
            ex_valid    <= 1'b0;
        end
    end

    // WB slot: capture on EX advance, hold while stalled, empty once consumed
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid  <= 1'b0;
            wb_result <= '0;
            wb_dest   <= '0;
            wb_err    <= 1'b0;
        end else if (ex_adv) begin
            wb_valid  <= 1'b1;
            wb_result <= ex_result;
            wb_dest   <= ex_dest;
            wb_err    <= ex_illegal;
        end else if (wb_fire) begin
            wb_valid  <= 1'b0;
        end
    end

    // Retire counter counts every consumed WB result and wraps naturally
    always_ff @(posedge clk) begin
        if (rst) begin
            retire_cnt <= '0;
        end else if (wb_fire) begin
            retire_cnt <= retire_cnt + 32'd1;
        end
    end

`ifdef EXE_BYPASS_EN
    // Forwarding view of both slots; writes to x0 are never advertised
    always_comb begin
        fwd_ex_valid = ex_valid & (ex_dest != '0);
        fwd_ex_dest  = ex_dest;
        fwd_ex_data  = ex_result;
        fwd_wb_valid = wb_valid & (wb_dest != '0);
        fwd_wb_dest  = wb_dest;
        fwd_wb_data  = wb_result;
    end
`else
    // Forwarding disabled: ports kept for a stable interface, driven to zero
    always_comb begin
        fwd_ex_valid = 1'b0;
        fwd_ex_dest  = '0;
        fwd_ex_data  = '0;
        fwd_wb_valid = 1'b0;
        fwd_wb_dest  = '0;
        fwd_wb_data  = '0;
    end
`endif

endmodule
